// File: rtl/hud_pkg.sv
// Shared types and constants for the HUD digit display path.
// Used by the score writer and its BCD correction cells.
package hud_pkg;

  localparam int          DIGIT_W    = 4;
  localparam int          HUD_IDX_W  = 4;
  localparam logic [3:0]  BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    WRITE   = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets 3 added
// so that the following left shift carries correctly into the next decade.
module bcd_add3
  import hud_pkg::*;
(
  input  logic [DIGIT_W-1:0] nibble,
  output logic [DIGIT_W-1:0] corrected
);

  assign corrected = (nibble >= DIGIT_W'(5)) ? nibble + DIGIT_W'(3) : nibble;

endmodule

// File: rtl/hud_score_writer.sv
// Converts a binary score into decimal digits with sequential double-dabble,
// then writes them MSD-first to the HUD digit registers over a ready handshake.
module hud_score_writer
  import hud_pkg::*;
#(
  parameter int VAL_WIDTH  = 32,
  parameter int NUM_DIGITS = 13,
  parameter bit BLANK_LZ   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [VAL_WIDTH-1:0] value_in,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 wr_en,
  output logic [HUD_IDX_W-1:0] wr_idx,
  output logic [DIGIT_W-1:0]   wr_digit,
  input  logic                 wr_ready
);

  localparam int BCD_W = DIGIT_W * NUM_DIGITS;
  localparam int CNT_W = $clog2(VAL_WIDTH + 1);

  state_t                 state, state_nxt;
  logic [VAL_WIDTH-1:0]   shift_q;
  logic [BCD_W-1:0]       bcd_q;
  logic [BCD_W-1:0]       bcd_corr;
  logic                   ovf_q;
  logic [CNT_W-1:0]       bit_cnt;
  logic [HUD_IDX_W-1:0]   idx_q;
  logic                   done_q;
  logic                   last_shift;
  logic                   last_write;
  logic                   transfer;
  logic [DIGIT_W-1:0]     slot_digit [NUM_DIGITS];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nibble    (bcd_q[g*DIGIT_W +: DIGIT_W]),
      .corrected (bcd_corr[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign last_shift = (bit_cnt == CNT_W'(VAL_WIDTH - 1));
  assign last_write = (idx_q == HUD_IDX_W'(NUM_DIGITS - 1));
  assign transfer   = wr_en && wr_ready;

  assign busy   = (state != IDLE);
  assign wr_en  = (state == WRITE);
  assign wr_idx = idx_q;
  assign done   = done_q;

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)                  state_nxt = CONVERT;
      CONVERT: if (last_shift)             state_nxt = WRITE;
      WRITE:   if (transfer && last_write) state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  // Slot 0 is the most significant nibble; a zero is blanked while every
  // more-significant nibble is also zero, except in the units slot.
  always_comb begin
    logic all_zero;
    logic [DIGIT_W-1:0] nib;
    all_zero = 1'b1;
    nib      = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      nib      = bcd_q[(NUM_DIGITS-1-k)*DIGIT_W +: DIGIT_W];
      all_zero = all_zero && (nib == '0);
      if (ovf_q)
        slot_digit[k] = DIGIT_W'(9);
      else if (BLANK_LZ && all_zero && (k != NUM_DIGITS - 1))
        slot_digit[k] = BLANK_CODE;
      else
        slot_digit[k] = nib;
    end
  end

  always_comb begin
    wr_digit = '0;
    if (state == WRITE) begin
      for (int k = 0; k < NUM_DIGITS; k++)
        if (idx_q == HUD_IDX_W'(k)) wr_digit = slot_digit[k];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      bit_cnt <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == WRITE) && transfer && last_write;
      unique case (state)
        IDLE: begin
          if (start) begin
            shift_q <= value_in;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            bit_cnt <= '0;
            idx_q   <= '0;
          end
        end
        CONVERT: begin
          {bcd_q, shift_q} <= {bcd_corr[BCD_W-2:0], shift_q, 1'b0};
          if (bcd_corr[BCD_W-1]) ovf_q <= 1'b1;
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        WRITE: begin
          if (transfer) idx_q <= idx_q + HUD_IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/hud_score_writer.md
Name: hud_score_writer

Overview:
Converts a binary value (score or tempo counter) into decimal digits and writes them one at a time into the per-digit number registers of the HUD digit display. It is the producer side of the HUD digit write interface: an index/digit/strobe triple with a ready handshake. Conversion is sequential shift-add-3 (double-dabble) followed by an MSD-first write burst. It sits between game/score logic and the HUD digit sprites.

Parameters:
VAL_WIDTH, 32, width of binary input value.
NUM_DIGITS, 13, number of HUD digit slots written; slot 0 is leftmost, i.e. the most significant digit.
BLANK_LZ, 1, 1 = leading zeros are written as BLANK_CODE; the least significant digit is never blanked.

Ports:
clk  input  1  system clock.
reset_n  input  1  asynchronous active-low reset.
value_in  input  VAL_WIDTH  binary value; sampled only when start is accepted.
start  input  1  request conversion; accepted only in IDLE.
busy  output  1  high from the cycle after acceptance until done.
done  output  1  one-cycle pulse after the last digit write.
wr_en  output  1  digit write strobe.
wr_idx  output  4  HUD digit slot, 0..NUM_DIGITS-1.
wr_digit  output  4  digit value 0-9, or BLANK_CODE.
wr_ready  input  1  HUD accepts the write this cycle.

Behaviour:
- Clock and reset: single clock. reset_n is asynchronous and active-low. Reset values: state=IDLE; busy=0; done=0; wr_en=0; wr_idx=0; wr_digit=0; internal shift and BCD registers=0.
- States: IDLE, CONVERT, WRITE.
- IDLE:
  - start=1 at an edge: load value_in into the shift register, clear the BCD register (4*NUM_DIGITS bits), clear the overflow flag and bit counter, go to CONVERT.
  - start in any other state is ignored; it is not queued.
- CONVERT (exactly VAL_WIDTH cycles), each cycle:
  - add 3 to every BCD nibble that is >=5;
  - shift {bcd, shift} left by 1;
  - if the bit shifted out of the BCD MSB is 1, set the sticky overflow flag;
  - after VAL_WIDTH shifts, go to WRITE with wr_idx=0.
- WRITE:
  - wr_en=1 with wr_idx/wr_digit valid.
  - A transfer occurs when wr_en && wr_ready. While wr_ready=0, wr_idx and wr_digit hold stable.
  - On transfer: increment wr_idx. If wr_idx was NUM_DIGITS-1, go to IDLE instead, deassert wr_en, and pulse done in that first IDLE cycle.
- Digit value for slot k: BCD nibble NUM_DIGITS-1-k.
  - Overflow set: every slot is written as 9 (saturate).
  - BLANK_LZ=1: a zero nibble with all more-significant nibbles also zero is written as BLANK_CODE, except slot NUM_DIGITS-1.
- busy: 1 in CONVERT and WRITE.
- Latency with wr_ready held high: start edge t; writes at t+VAL_WIDTH+1 .. t+VAL_WIDTH+NUM_DIGITS; done at t+VAL_WIDTH+NUM_DIGITS+1. Each stalled cycle adds 1.
- Simultaneous events: start during the done cycle is accepted, since the state is already IDLE.
- value_in changing while busy: no effect.
- Reset mid-CONVERT or mid-WRITE:
  - immediate return to IDLE; wr_en drops asynchronously;
  - no done pulse;
  - partially written HUD slots are left as written.
- Width rule: the index counter must hold NUM_DIGITS (NUM_DIGITS <= 15).

Decomposition:
- Shared package hud_pkg: DIGIT_W=4, BLANK_CODE=4'hF, HUD_IDX_W=4, and the state enum (IDLE/CONVERT/WRITE).
- One natural sub-module: bcd_add3, a combinational per-nibble >=5 add-3 correction, instantiated NUM_DIGITS times in a generate loop.

Test Plan:
- value_in=0, BLANK_LZ=1, wr_ready=1 -> slots 0..11 = 4'hF, slot 12 = 0; done exactly 46 cycles after the start edge.
- value_in=32'hFFFFFFFF -> digits 0,0,0,4,2,9,4,9,6,7,2,9,5 with BLANK_LZ=0, and F,F,F,4,2,9,4,9,6,7,2,9,5 with BLANK_LZ=1.
- value_in=1234 with wr_ready low every other cycle -> idx/digit held while stalled, 13 transfers total ending …1,2,3,4, done one cycle after the last transfer.
- Second start pulsed mid-CONVERT with value 99 -> ignored; output reflects the first value; start on the done cycle is accepted.
- reset_n low during WRITE at idx 5 -> wr_en=0 immediately, busy=0, no done; a new start afterwards completes normally.
- VAL_WIDTH=16, NUM_DIGITS=4, value 65535 -> overflow; all four slots written 9.
